// File: rtl/phaser_demodulator.sv
// rtl/phaser_demodulator.sv - re-pairs 4-bit phase words into 2-bit symbols and packs them into bytes
// Loopback receiver for the tag phase modulator; flags illegal pairs and gap timeouts.
module phaser_demodulator #(
  parameter int ERR_W   = 8,
  parameter int GAP_MAX = 255
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             frame_start,
  input  logic             phase_valid,
  input  logic [3:0]       phase_word,
  output logic [1:0]       symbol,
  output logic             symbol_valid,
  output logic             symbol_mode,
  output logic [7:0]       byte_out,
  output logic             byte_valid,
  output logic             pair_error,
  output logic [ERR_W-1:0] error_count,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, FIRST, SECOND} state_t;

  localparam int GAP_W = $clog2(GAP_MAX + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_MAX - 1);

  state_t           state_q, state_d;
  logic [3:0]       held_q, held_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [1:0]       slot_q, slot_d;
  logic [5:0]       pack_q, pack_d;
  logic [1:0]       sym_q, sym_d;
  logic             mode_q, mode_d;
  logic             sv_q, sv_d;
  logic [7:0]       byte_q, byte_d;
  logic             bv_q, bv_d;
  logic             pe_q, pe_d;
  logic [ERR_W-1:0] ecnt_q, ecnt_d;

  logic       word_legal;
  logic [3:0] held_partner;
  logic [1:0] held_sym;
  logic       take_first, good, err, clear_pack;

  // Legal first halves are {1,3,5,7} (mode1) and {2,6,A,E} (mode0), so w[0] alone tells the mode once legal.
  assign word_legal   = (phase_word[0] && !phase_word[3]) || (phase_word[1:0] == 2'b10);
  assign held_partner = held_q[0] ? (held_q ^ 4'h4) : (held_q ^ 4'h8);
  assign held_sym     = held_q[0] ? held_q[2:1] : held_q[3:2];

  always_comb begin
    state_d    = state_q;
    held_d     = held_q;
    gap_d      = gap_q;
    slot_d     = slot_q;
    pack_d     = pack_q;
    sym_d      = sym_q;
    mode_d     = mode_q;
    sv_d       = 1'b0;
    byte_d     = byte_q;
    bv_d       = 1'b0;
    pe_d       = 1'b0;
    ecnt_d     = ecnt_q;
    take_first = 1'b0;
    good       = 1'b0;
    err        = 1'b0;
    clear_pack = 1'b0;

    if (frame_start) begin
      // Resync from any state: drop a held first half silently and restart the byte.
      clear_pack = 1'b1;
      gap_d      = '0;
      state_d    = FIRST;
      take_first = phase_valid;
    end else begin
      case (state_q)
        IDLE: ;
        FIRST: take_first = phase_valid;
        SECOND: begin
          if (phase_valid) begin
            state_d = FIRST;
            if (phase_word == held_partner) begin
              good = 1'b1;
            end else begin
              err        = 1'b1;
              clear_pack = 1'b1;
            end
          end else if (gap_q == GAP_LAST) begin
            err     = 1'b1;
            gap_d   = '0;
            state_d = FIRST;
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (take_first) begin
      if (word_legal) begin
        held_d  = phase_word;
        gap_d   = '0;
        state_d = SECOND;
      end else begin
        err     = 1'b1;
        state_d = FIRST;
      end
    end

    if (clear_pack) begin
      slot_d = '0;
      pack_d = '0;
    end

    if (good) begin
      sym_d  = held_sym;
      mode_d = held_q[0];
      sv_d   = 1'b1;
      if (slot_q == 2'd3) begin
        byte_d = {pack_q, held_sym};
        bv_d   = 1'b1;
        slot_d = '0;
        pack_d = '0;
      end else begin
        pack_d = {pack_q[3:0], held_sym};
        slot_d = slot_q + 2'd1;
      end
    end

    if (err) begin
      pe_d = 1'b1;
      if (!(&ecnt_q)) ecnt_d = ecnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      held_q  <= '0;
      gap_q   <= '0;
      slot_q  <= '0;
      pack_q  <= '0;
      sym_q   <= '0;
      mode_q  <= 1'b0;
      sv_q    <= 1'b0;
      byte_q  <= '0;
      bv_q    <= 1'b0;
      pe_q    <= 1'b0;
      ecnt_q  <= '0;
    end else begin
      state_q <= state_d;
      held_q  <= held_d;
      gap_q   <= gap_d;
      slot_q  <= slot_d;
      pack_q  <= pack_d;
      sym_q   <= sym_d;
      mode_q  <= mode_d;
      sv_q    <= sv_d;
      byte_q  <= byte_d;
      bv_q    <= bv_d;
      pe_q    <= pe_d;
      ecnt_q  <= ecnt_d;
    end
  end

  assign symbol       = sym_q;
  assign symbol_mode  = mode_q;
  assign symbol_valid = sv_q;
  assign byte_out     = byte_q;
  assign byte_valid   = bv_q;
  assign pair_error   = pe_q;
  assign error_count  = ecnt_q;
  assign busy         = (state_q == SECOND);

endmodule

// File: tb/tb_phaser_demodulator.sv
// tb/tb_phaser_demodulator.sv - self-checking bench for phaser_demodulator
// Directed scenarios plus randomized words, checked each cycle against a queue-based model.
module tb_phaser_demodulator;

  localparam int ERR_W   = 8;
  localparam int GAP_MAX = 255;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             frame_start = 1'b0;
  logic             phase_valid = 1'b0;
  logic [3:0]       phase_word = 4'h0;
  logic [1:0]       symbol;
  logic             symbol_valid;
  logic             symbol_mode;
  logic [7:0]       byte_out;
  logic             byte_valid;
  logic             pair_error;
  logic [ERR_W-1:0] error_count;
  logic             busy;

  phaser_demodulator #(.ERR_W(ERR_W), .GAP_MAX(GAP_MAX)) dut (
    .clock(clock), .reset(reset), .frame_start(frame_start),
    .phase_valid(phase_valid), .phase_word(phase_word),
    .symbol(symbol), .symbol_valid(symbol_valid), .symbol_mode(symbol_mode),
    .byte_out(byte_out), .byte_valid(byte_valid), .pair_error(pair_error),
    .error_count(error_count), .busy(busy)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  bit check_en = 1'b0;
  int sym_seen = 0;
  int byte_seen = 0;

  logic [3:0] legal_w [8] = '{4'h1, 4'h3, 4'h5, 4'h7, 4'h2, 4'h6, 4'hA, 4'hE};
  logic [3:0] illegal_w [8] = '{4'h0, 4'h4, 4'h8, 4'hC, 4'h9, 4'hB, 4'hD, 4'hF};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: words are looked up against the spec's tables; symbols collect in a queue until four arrive.
  function automatic bit legal_first(input logic [3:0] w);
    for (int i = 0; i < 8; i++) if (legal_w[i] == w) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [3:0] partner(input logic [3:0] w);
    return w[0] ? (w ^ 4'h4) : (w ^ 4'h8);
  endfunction

  function automatic logic [1:0] sym_of(input logic [3:0] w);
    return w[0] ? w[2:1] : w[3:2];
  endfunction

  bit         m_synced, m_holding;
  logic [3:0] m_held;
  int         m_gap, m_err;
  int         m_q[$];
  logic [1:0] e_sym;
  bit         e_mode, e_sv, e_bv, e_pe;
  logic [7:0] e_byte;

  task automatic model_err();
    e_pe = 1'b1;
    if (m_err < 2**ERR_W - 1) m_err++;
  endtask

  task automatic model_first(input logic [3:0] w);
    if (legal_first(w)) begin
      m_held = w;
      m_holding = 1'b1;
      m_gap = 0;
    end else begin
      model_err();
    end
  endtask

  task automatic model_good(input logic [3:0] w);
    e_sym  = sym_of(w);
    e_mode = w[0];
    e_sv   = 1'b1;
    m_q.push_back(int'(sym_of(w)));
    if (m_q.size() == 4) begin
      e_byte = 8'(m_q[0] * 64 + m_q[1] * 16 + m_q[2] * 4 + m_q[3]);
      e_bv = 1'b1;
      m_q.delete();
    end
  endtask

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_synced = 0; m_holding = 0; m_held = 0; m_gap = 0; m_err = 0;
      m_q.delete();
      e_sym = 0; e_mode = 0; e_sv = 0; e_bv = 0; e_pe = 0; e_byte = 0;
    end else begin
      e_sv = 0; e_bv = 0; e_pe = 0;
      if (frame_start) begin
        m_synced = 1; m_holding = 0; m_gap = 0;
        m_q.delete();
        if (phase_valid) model_first(phase_word);
      end else if (!m_synced) begin
        m_gap = 0;
      end else if (!m_holding) begin
        if (phase_valid) model_first(phase_word);
      end else if (phase_valid) begin
        m_holding = 0;
        if (phase_word == partner(m_held)) model_good(m_held);
        else begin
          model_err();
          m_q.delete();
        end
      end else begin
        m_gap++;
        if (m_gap >= GAP_MAX) begin
          m_holding = 0;
          model_err();
        end
      end
    end
  end

  always @(negedge clock) begin
    if (check_en) begin
      chk("symbol_valid", symbol_valid, e_sv);
      chk("pair_error", pair_error, e_pe);
      chk("byte_valid", byte_valid, e_bv);
      chk("byte_out", byte_out, e_byte);
      chk("error_count", error_count, m_err);
      chk("busy", busy, m_holding);
      if (e_sv) begin
        chk("symbol", symbol, e_sym);
        chk("symbol_mode", symbol_mode, e_mode);
      end
      if (symbol_valid) sym_seen++;
      if (byte_valid) byte_seen++;
    end
  end

  task automatic drive(input logic fs, input logic v, input logic [3:0] w);
    frame_start = fs;
    phase_valid = v;
    phase_word  = w;
    @(posedge clock);
    @(negedge clock);
    #1;
  endtask

  logic [3:0] seq1 [8] = '{4'h1, 4'h5, 4'h3, 4'h7, 4'h5, 4'h1, 4'h7, 4'h3};
  logic [3:0] seq2 [8] = '{4'h2, 4'hA, 4'h6, 4'hE, 4'hA, 4'h2, 4'hE, 4'h6};

  initial begin
    int s0, b0;
    logic [3:0] w;
    bit fs, v;

    repeat (2) @(negedge clock);
    #1;
    chk("rst_symbol_valid", symbol_valid, 0);
    chk("rst_byte_out", byte_out, 0);
    chk("rst_error_count", error_count, 0);
    chk("rst_busy", busy, 0);
    check_en = 1'b1;
    reset = 1'b0;

    drive(1, 0, 0);
    foreach (seq1[i]) drive(0, 1, seq1[i]);
    chk("t1_byte_valid", byte_valid, 1);
    chk("t1_byte_out", byte_out, 8'h1B);
    chk("t1_symbol", symbol, 3);
    drive(0, 0, 0);
    chk("t1_byte_valid_drop", byte_valid, 0);
    chk("t1_byte_hold", byte_out, 8'h1B);

    foreach (seq2[i]) drive(0, 1, seq2[i]);
    chk("t2_byte_out", byte_out, 8'h1B);
    chk("t2_mode", symbol_mode, 0);

    drive(0, 1, 4'h3);
    drive(0, 1, 4'h6);
    chk("t3_pair_error", pair_error, 1);
    chk("t3_error_count", error_count, 1);
    chk("t3_no_symbol", symbol_valid, 0);
    drive(0, 1, 4'h3);
    drive(0, 1, 4'h7);
    chk("t3_symbol_valid", symbol_valid, 1);
    chk("t3_symbol", symbol, 1);

    s0 = sym_seen;
    drive(0, 1, 4'h1);
    repeat (GAP_MAX - 1) drive(0, 0, 0);
    chk("t4_no_early_timeout", pair_error, 0);
    drive(0, 0, 0);
    chk("t4_timeout", pair_error, 1);
    chk("t4_busy", busy, 0);
    chk("t4_no_symbol", sym_seen, s0);

    drive(1, 0, 0);
    repeat (3) begin drive(0, 1, 4'h1); drive(0, 1, 4'h5); end
    b0 = byte_seen;
    drive(1, 0, 0);
    repeat (4) begin drive(0, 1, 4'h7); drive(0, 1, 4'h3); end
    chk("t5_byte_out", byte_out, 8'hFF);
    chk("t5_one_byte", byte_seen, b0 + 1);

    for (int i = 0; i < 3000; i++) begin
      fs = ($urandom_range(99) < 3);
      v  = ($urandom_range(99) < 75);
      if (m_holding && $urandom_range(9) < 7) w = partner(m_held);
      else if ($urandom_range(1) == 1) w = legal_w[$urandom_range(7)];
      else w = 4'($urandom_range(15));
      drive(fs, v, w);
    end

    drive(1, 0, 0);
    repeat (2**ERR_W + 3) drive(0, 1, illegal_w[$urandom_range(7)]);
    chk("t6_saturated", error_count, 8'hFF);
    drive(0, 1, 4'h1);
    chk("t6_busy_mid_pair", busy, 1);
    #1 reset = 1'b1;
    #1;
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_error_count", error_count, 0);
    chk("t6_rst_byte_out", byte_out, 0);
    chk("t6_rst_pair_error", pair_error, 0);
    @(negedge clock);
    #1 reset = 1'b0;
    drive(0, 1, 4'h1);
    drive(0, 1, 4'h5);
    chk("t6_idle_no_symbol", symbol_valid, 0);
    chk("t6_idle_busy", busy, 0);

    check_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
